// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the divided-clock monitors: FSM states,
// the high-time acceptance window and the counter ceiling.
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } mon_state_t;

   localparam int DEF_CNT_W = 8;
   localparam int CNT_MAX   = (1 << DEF_CNT_W) - 1;

   // Saturation ceiling for a counter of the given width
   function automatic int cnt_max(input int width);
      return (1 << width) - 1;
   endfunction

   // An odd divider cannot be exactly 50%, so accept floor(N/2)..ceil(N/2)
   function automatic logic high_in_window(input int exp_div, input int high);
      return (high >= exp_div / 2) && (high <= (exp_div + 1) / 2);
   endfunction

endpackage

// File: rtl/clk_edge_sampler.sv
// Two-stage sampler treating a divided clock as data and flagging its
// rising edges in the source clock domain.
module clk_edge_sampler (
   input  logic clk_in,
   input  logic rst_n,
   input  logic clk_div,
   output logic sampled,
   output logic rise
);

   logic s2;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sampled <= 1'b0;
         s2      <= 1'b0;
      end else begin
         sampled <= clk_div;
         s2      <= sampled;
      end
   end

   assign rise = sampled & ~s2;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in clk_in cycles,
// declares lock after LOCK_CNT good periods and flags wrong-ratio or stuck clocks.
module clk_div_monitor
   import clk_div_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int EXP_DIV  = 3,
   parameter int LOCK_CNT = 4
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             clk_div,
   input  logic             en,
   input  logic             err_clr,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_cnt,
   output logic             meas_valid,
   output logic             locked,
   output logic             err,
   output logic             stuck
);

   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(cnt_max(CNT_W));
   localparam logic [CNT_W-1:0] EXP_VAL  = CNT_W'(EXP_DIV);
   localparam logic [3:0]       LOCK_TOP = 4'(LOCK_CNT);

   mon_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hcnt;
   logic [3:0]       lock_cnt;
   logic [3:0]       lock_next;
   logic             period_match;
   logic             s1;
   logic             rise;

   clk_edge_sampler u_sampler (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .clk_div (clk_div),
      .sampled (s1),
      .rise    (rise)
   );

   always_comb begin
      period_match = (cnt == EXP_VAL) && high_in_window(EXP_DIV, int'(hcnt));
      lock_next    = (lock_cnt == LOCK_TOP) ? lock_cnt : lock_cnt + 4'd1;
   end

   // The rise cycle both closes the running period and starts the next one,
   // so cnt/hcnt reload to 1 rather than 0.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         hcnt       <= '0;
         lock_cnt   <= '0;
         period     <= '0;
         high_cnt   <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
         stuck      <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (err_clr) begin
            err   <= 1'b0;
            stuck <= 1'b0;
         end
         if (!en) begin
            state    <= IDLE;
            cnt      <= '0;
            hcnt     <= '0;
            lock_cnt <= '0;
            locked   <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  state <= ARM;
               end
               ARM: begin
                  if (rise) begin
                     cnt   <= CNT_W'(1);
                     hcnt  <= CNT_W'(1);
                     state <= MEAS;
                  end
               end
               MEAS: begin
                  if (rise) begin
                     period     <= cnt;
                     high_cnt   <= hcnt;
                     meas_valid <= 1'b1;
                     cnt        <= CNT_W'(1);
                     hcnt       <= CNT_W'(1);
                     if (period_match) begin
                        lock_cnt <= lock_next;
                        locked   <= (lock_next == LOCK_TOP);
                     end else begin
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                        err      <= 1'b1;
                     end
                  end else if (cnt == CNT_TOP) begin
                     // No edge for a full counter span: give up on this period and re-arm
                     stuck    <= 1'b1;
                     locked   <= 1'b0;
                     lock_cnt <= '0;
                     cnt      <= '0;
                     hcnt     <= '0;
                     state    <= ARM;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                     if (s1 && (hcnt != CNT_TOP)) begin
                        hcnt <= hcnt + CNT_W'(1);
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
